// File: rtl/charbuf_pkg.sv
// Shared definitions for the text-line producer path.
//   LINE_LEN_DEFAULT : characters per display line
//   ASCII_*          : control bytes recognised by the writer
//   char_t           : one display cell (bit 0 is the MSB)
//   charbuf_state_e  : writer FSM states
package charbuf_pkg;

   localparam int LINE_LEN_DEFAULT = 11;

   localparam logic [7:0] ASCII_NUL = 8'd0;
   localparam logic [7:0] ASCII_BS  = 8'd8;
   localparam logic [7:0] ASCII_CR  = 8'd13;

   typedef logic [0:7] char_t;

   typedef enum logic [1:0] {
      ACCEPT,
      PENDING,
      SWAP
   } charbuf_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Single-register edge detector for sync pulses.
// Flags the cycle in which the sync input first shows its active level,
// by comparing the registered previous value against the current value.
// Ports:
//   clk        : clock
//   srst       : synchronous active-high reset (register loads the inactive level)
//   sig        : sync input
//   edge_pulse : high for the cycle where the active transition is seen
// Parameter ACTIVE_LOW selects a falling (1) or rising (0) active transition.
module sync_edge_detect #(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic clk,
   input  logic srst,
   input  logic sig,
   output logic edge_pulse
);

   logic sig_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         sig_reg <= ACTIVE_LOW;
      end else begin
         sig_reg <= sig;
      end
   end

   assign edge_pulse = ACTIVE_LOW ? (sig_reg & ~sig) : (~sig_reg & sig);

endmodule

// File: rtl/charbuf_writer.sv
// Producer side of the text-line path. Bytes arriving on a valid/ready
// handshake edit a shadow line; a carriage return queues a commit of the
// shadow line to the display array, applied at the start of the next
// vertical sync pulse so the VGA text controller never sees a torn line.
// Ports:
//   clock_25   : pixel clock, all logic on its rising edge
//   reset      : synchronous active-high reset
//   char_in    : ASCII byte from the producer
//   char_valid : char_in valid this cycle
//   char_ready : a byte can be accepted this cycle
//   vsync      : vertical sync from the sincronizador
//   char       : display array, 8'd0 is a blank cell
//   busy       : a commit is waiting for the sync pulse
//   overflow   : sticky, a printable byte was dropped on a full line
// Build option CHARBUF_SCROLL_EN: a printable byte on a full line scrolls the
// shadow left by one cell instead of being dropped; overflow is then tied low.
module charbuf_writer
   import charbuf_pkg::*;
#(
   parameter int LINE_LEN         = LINE_LEN_DEFAULT,
   parameter int VSYNC_ACTIVE_LOW = 1
) (
   input  logic       clock_25,
   input  logic       reset,
   input  logic [7:0] char_in,
   input  logic       char_valid,
   output logic       char_ready,
   input  logic       vsync,
   output logic [0:7] char [0:LINE_LEN-1],
   output logic       busy,
   output logic       overflow
);

   localparam logic [3:0] LINE_LEN_P = 4'(LINE_LEN);

   charbuf_state_e state_reg;
   logic           ready_reg;
   logic           busy_reg;
   logic [3:0]     ptr_reg;
   logic [3:0]     ptr_next;
   char_t          shadow_reg  [0:LINE_LEN-1];
   char_t          shadow_next [0:LINE_LEN-1];
   char_t          char_reg    [0:LINE_LEN-1];

   logic sync_edge;
   logic byte_fire;
   logic is_cr;
   logic is_bs;
   logic is_print;
   logic line_full;
`ifndef CHARBUF_SCROLL_EN
   logic drop_byte;
   logic overflow_reg;
`endif

   sync_edge_detect #(
      .ACTIVE_LOW (VSYNC_ACTIVE_LOW != 0)
   ) u_vsync_edge (
      .clk        (clock_25),
      .srst       (reset),
      .sig        (vsync),
      .edge_pulse (sync_edge)
   );

   // ready_reg is high only in ACCEPT, so it doubles as the state gate.
   assign byte_fire = ready_reg & char_valid;
   assign is_cr     = (char_in == ASCII_CR);
   assign is_bs     = (char_in == ASCII_BS);
   assign is_print  = !(is_cr || is_bs || (char_in == ASCII_NUL));
   assign line_full = (ptr_reg == LINE_LEN_P);

   // Shadow line editing; CR and NUL leave the shadow untouched.
   always_comb begin
      shadow_next = shadow_reg;
      ptr_next    = ptr_reg;
`ifndef CHARBUF_SCROLL_EN
      drop_byte   = 1'b0;
`endif
      if (state_reg == SWAP) begin
         for (int i = 0; i < LINE_LEN; i++) begin
            shadow_next[i] = '0;
         end
         ptr_next = '0;
      end else if (byte_fire) begin
         if (is_bs && (ptr_reg != 4'd0)) begin
            ptr_next                      = ptr_reg - 4'd1;
            shadow_next[ptr_reg - 4'd1]   = '0;
         end else if (is_print && !line_full) begin
            shadow_next[ptr_reg] = char_in;
            ptr_next             = ptr_reg + 4'd1;
         end else if (is_print) begin
`ifdef CHARBUF_SCROLL_EN
            for (int i = 0; i < LINE_LEN - 1; i++) begin
               shadow_next[i] = shadow_reg[i+1];
            end
            shadow_next[LINE_LEN-1] = char_in;
`else
            drop_byte = 1'b1;
`endif
         end
      end
   end

   // Line storage. The display copy only changes in SWAP.
   always_ff @(posedge clock_25) begin
      if (reset) begin
         for (int i = 0; i < LINE_LEN; i++) begin
            shadow_reg[i] <= '0;
            char_reg[i]   <= '0;
         end
         ptr_reg <= '0;
      end else begin
         shadow_reg <= shadow_next;
         ptr_reg    <= ptr_next;
         if (state_reg == SWAP) begin
            char_reg <= shadow_reg;
         end
      end
   end

   // Control FSM with registered handshake/status outputs.
   always_ff @(posedge clock_25) begin
      if (reset) begin
         state_reg <= ACCEPT;
         ready_reg <= 1'b1;
         busy_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ACCEPT: begin
               if (byte_fire && is_cr) begin
                  state_reg <= PENDING;
                  ready_reg <= 1'b0;
                  busy_reg  <= 1'b1;
               end
            end
            PENDING: begin
               if (sync_edge) begin
                  state_reg <= SWAP;
               end
            end
            SWAP: begin
               state_reg <= ACCEPT;
               ready_reg <= 1'b1;
               busy_reg  <= 1'b0;
            end
            default: begin
               state_reg <= ACCEPT;
               ready_reg <= 1'b1;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

`ifdef CHARBUF_SCROLL_EN
   assign overflow = 1'b0;
`else
   always_ff @(posedge clock_25) begin
      if (reset || (state_reg == SWAP)) begin
         overflow_reg <= 1'b0;
      end else if (drop_byte) begin
         overflow_reg <= 1'b1;
      end
   end
   assign overflow = overflow_reg;
`endif

   for (genvar gi = 0; gi < LINE_LEN; gi++) begin : g_char_out
      assign char[gi] = char_reg[gi];
   end

   assign char_ready = ready_reg;
   assign busy       = busy_reg;

endmodule

// File: tb/tb_charbuf_writer.sv
// Self-checking bench for charbuf_writer: a table of typed lines with their
// expected display contents, hand-written multi-cycle sequences, and a
// randomized byte stream checked against a queue-based line model.
module tb_charbuf_writer;

   localparam int L = 11;
`ifdef CHARBUF_SCROLL_EN
   localparam bit SCROLL = 1'b1;
`else
   localparam bit SCROLL = 1'b0;
`endif

   logic       clock_25 = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] char_in = 8'd0;
   logic       char_valid = 1'b0;
   logic       vsync = 1'b1;
   logic       char_ready;
   logic       busy;
   logic       overflow;
   logic [0:7] char_o [0:L-1];

   always #20 clock_25 = ~clock_25;

   charbuf_writer #(
      .LINE_LEN         (L),
      .VSYNC_ACTIVE_LOW (1)
   ) dut (
      .clock_25   (clock_25),
      .reset      (reset),
      .char_in    (char_in),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .vsync      (vsync),
      .char       (char_o),
      .busy       (busy),
      .overflow   (overflow)
   );

   int errors = 0;
   int checks = 0;

   // Line model: typed text as a queue, committed copy as an array.
   byte unsigned m_sh[$];
   byte unsigned m_disp[L];
   bit           m_pending;
   bit           m_ovf;

   typedef struct {
      string keys;
      string line;
      bit    ovf;
   } vec_t;
   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_vec(input string name, input logic [8*L-1:0] exp);
      logic [8*L-1:0] act;
      for (int i = 0; i < L; i++) act[8*(L-1-i) +: 8] = char_o[i];
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_disp(input string name);
      logic [8*L-1:0] exp;
      for (int i = 0; i < L; i++) exp[8*(L-1-i) +: 8] = m_disp[i];
      chk_vec(name, exp);
   endtask

   task automatic chk_line(input string name, input string line);
      logic [8*L-1:0] exp;
      for (int i = 0; i < L; i++) exp[8*(L-1-i) +: 8] = (i < line.len()) ? line[i] : 8'd0;
      chk_vec(name, exp);
   endtask

   task automatic model_reset();
      m_sh.delete();
      for (int i = 0; i < L; i++) m_disp[i] = 8'd0;
      m_pending = 1'b0;
      m_ovf     = 1'b0;
   endtask

   task automatic model_byte(input byte unsigned b);
      if (b == 8'd13) m_pending = 1'b1;
      else if (b == 8'd8) begin
         if (m_sh.size() > 0) void'(m_sh.pop_back());
      end else if (b == 8'd0) begin
      end else if (m_sh.size() < L) m_sh.push_back(b);
      else if (SCROLL) begin
         void'(m_sh.pop_front());
         m_sh.push_back(b);
      end else m_ovf = 1'b1;
   endtask

   task automatic model_commit();
      if (m_pending) begin
         for (int i = 0; i < L; i++) m_disp[i] = (i < m_sh.size()) ? m_sh[i] : 8'd0;
         m_sh.delete();
         m_ovf     = 1'b0;
         m_pending = 1'b0;
      end
   endtask

   task automatic send_byte(input byte unsigned b);
      int n;
      @(negedge clock_25);
      char_in    = b;
      char_valid = 1'b1;
      chk("ready_at_send", char_ready, 1);
      n = 0;
      while (!char_ready && n < 100) begin
         @(negedge clock_25);
         n++;
      end
      if (!char_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got ready=0 expected ready=1 within 100 cycles");
         char_valid = 1'b0;
         return;
      end
      @(negedge clock_25);
      char_valid = 1'b0;
      model_byte(b);
      $display("tx byte=%0d ovf=%0b busy=%0b", b, overflow, busy);
      chk("overflow_after_byte", overflow, m_ovf);
      chk("busy_after_byte", busy, m_pending);
   endtask

   task automatic pulse_vsync(input string name);
      bit was_pending;
      was_pending = m_pending;
      @(negedge clock_25);
      vsync = 1'b0;
      @(negedge clock_25);
      chk("ready_in_swap", char_ready, !was_pending);
      chk("busy_in_swap", busy, was_pending);
      @(negedge clock_25);
      model_commit();
      chk_disp(name);
      @(negedge clock_25);
      chk("ready_after_swap", char_ready, 1);
      chk("busy_after_swap", busy, 0);
      chk("overflow_after_swap", overflow, m_ovf);
      $display("vsync commit=%0b line=%s", was_pending, name);
      vsync = 1'b1;
      @(negedge clock_25);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: got no finish expected finish before 5ms");
      $fatal(1, "watchdog");
   end

   initial begin
      byte unsigned b;
      int r;
      int bad;

      vecs[0].keys = "HOLA";          vecs[0].line = "HOLA";  vecs[0].ovf = 1'b0;
      vecs[1].keys = "ABC\010D";      vecs[1].line = "ABD";   vecs[1].ovf = 1'b0;
      vecs[2].keys = "0123456789AB";
      vecs[2].line = SCROLL ? "123456789AB" : "0123456789A";
      vecs[2].ovf  = !SCROLL;
      vecs[3].keys = "\010\010Q";     vecs[3].line = "Q";     vecs[3].ovf = 1'b0;
      vecs[4].keys = "AB\010\010\010Z"; vecs[4].line = "Z";   vecs[4].ovf = 1'b0;

      // Reset state.
      model_reset();
      repeat (3) @(negedge clock_25);
      reset = 1'b0;
      @(negedge clock_25);
      chk("reset_ready", char_ready, 1);
      chk("reset_busy", busy, 0);
      chk("reset_overflow", overflow, 0);
      chk_line("reset_char", "");

      // Table of typed lines.
      for (int v = 0; v < 5; v++) begin
         for (int k = 0; k < vecs[v].keys.len(); k++) send_byte(vecs[v].keys[k]);
         chk("row_overflow", overflow, vecs[v].ovf);
         send_byte(8'd13);
         chk("row_busy_after_cr", busy, 1);
         chk_disp("row_char_before_edge");
         pulse_vsync(vecs[v].line);
         chk_line("row_char_after_edge", vecs[v].line);
         chk("row_overflow_cleared", overflow, 0);
      end

      // Byte held valid while a commit is pending.
      send_byte(8'd13);
      @(negedge clock_25);
      char_in    = 8'd88;
      char_valid = 1'b1;
      bad = 0;
      repeat (50) begin
         @(negedge clock_25);
         if (char_ready || !busy) bad++;
      end
      chk("hold_not_ready_cycles", bad, 0);
      chk_disp("hold_char_unchanged");
      vsync = 1'b0;
      @(negedge clock_25);
      chk("hold_ready_in_swap", char_ready, 0);
      @(negedge clock_25);
      model_commit();
      chk("hold_ready_after_swap", char_ready, 1);
      chk_line("hold_char_empty_line", "");
      @(negedge clock_25);
      model_byte(8'd88);
      char_valid = 1'b0;
      vsync      = 1'b1;
      $display("tx byte=88 held through pending");
      send_byte(8'd13);
      pulse_vsync("X");
      chk_line("hold_x_first_byte", "X");

      // Reset in the middle of a pending commit.
      send_byte(8'd88);
      send_byte(8'd89);
      send_byte(8'd13);
      @(negedge clock_25);
      reset = 1'b1;
      @(negedge clock_25);
      reset = 1'b0;
      model_reset();
      @(negedge clock_25);
      chk("midreset_busy", busy, 0);
      chk("midreset_ready", char_ready, 1);
      pulse_vsync("midreset_edge");
      chk_line("midreset_char_blank", "");
      send_byte(8'd13);
      pulse_vsync("midreset_empty_shadow");
      chk_line("midreset_shadow_empty", "");

      // Sync edge while still typing.
      send_byte(8'd65);
      send_byte(8'd66);
      pulse_vsync("idle_edge");
      chk_line("idle_edge_char_unchanged", "");
      send_byte(8'd13);
      pulse_vsync("AB");
      chk_line("idle_edge_then_commit", "AB");

      // Randomized stream against the model.
      for (int it = 0; it < 300; it++) begin
         r = $urandom_range(0, 99);
         if (r < 26 && r >= 22) begin
            pulse_vsync("rand_idle_edge");
            continue;
         end
         if (r < 8) b = 8'd13;
         else if (r < 18) b = 8'd8;
         else if (r < 22) b = 8'd0;
         else b = 8'($urandom_range(32, 126));
         send_byte(b);
         if (b == 8'd13) pulse_vsync("rand_commit");
      end
      send_byte(8'd13);
      pulse_vsync("rand_final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/charbuf_writer.md
Name: charbuf_writer

Overview:
- Producer side of the text-line path. Accepts a stream of ASCII bytes over a valid/ready handshake and edits a shadow line of 11 characters.
- On a carriage return, it commits the shadow line to the 11-character display array read by the VGA text controller.
- The commit is applied only at the start of the vertical sync pulse, so a line never tears mid-frame.
- Runs in the 25 MHz pixel domain, next to the VGA controller.

Parameters:
- LINE_LEN, 11, number of characters per line; fixed by the display array width.
- VSYNC_ACTIVE_LOW, 1, when 1 the sync pulse starts on a vsync falling edge; when 0, on a rising edge.

Ports:
- clock_25  input  1  pixel clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- char_in  input  8  ASCII byte from the producer.
- char_valid  input  1  char_in is valid this cycle.
- char_ready  output  1  block can accept a byte this cycle.
- vsync  input  1  vertical sync from the sincronizador output.
- char  output  LINE_LEN x 8  display array, unpacked [0:LINE_LEN-1] of [0:7]; 8'd0 means a blank cell.
- busy  output  1  a commit is pending the next sync pulse.
- overflow  output  1  sticky; a printable byte was dropped because the line was full.

Behaviour:
- Transfer: a byte transfers on any cycle where char_valid and char_ready are both high. char_ready does not depend on char_valid or char_in.
- States:
  - ACCEPT: char_ready=1.
  - PENDING: char_ready=0, busy=1; waiting for the sync edge.
  - SWAP: a single cycle, char_ready=0, busy=1.
- Byte classes accepted in ACCEPT:
  - CR (8'd13): go to PENDING. The shadow line and pointer are held.
  - BS (8'd8): if ptr>0, then ptr-=1 and shadow[ptr]=8'd0. If ptr==0, no effect.
  - NUL (8'd0): ignored.
  - Any other byte is printable:
    - If ptr<LINE_LEN: shadow[ptr]=char_in and ptr+=1.
    - If ptr==LINE_LEN (full): byte dropped, overflow set to 1.
- Pointer: ptr is 4 bits, range 0..LINE_LEN, with no wrap-around.
- Sync edge: vsync is registered once. The edge is the active transition (falling when VSYNC_ACTIVE_LOW=1) between the registered and current values.
- PENDING -> SWAP on the first edge cycle.
- In SWAP: char <= shadow, shadow cleared to all 8'd0, ptr=0, overflow cleared, then go to ACCEPT.
- Latency:
  - char updates on the cycle after the edge is detected.
  - char_ready returns high 2 cycles after the edge.
- Edge seen in ACCEPT: no effect. char is never modified outside SWAP.
- CR when full: accepted normally.
- char_valid held during PENDING: not accepted, and the byte stays presented.
- Reset, whenever asserted (including mid-PENDING):
  - state=ACCEPT, ptr=0, shadow and char all 8'd0.
  - char_ready=1 on the cycle after reset deasserts, busy=0, overflow=0.
  - Registered vsync is loaded with the inactive level.

Optional Feature:
- Macro: CHARBUF_SCROLL_EN.
- Defined: a printable byte received when ptr==LINE_LEN shifts the shadow left by one cell (shadow[i]=shadow[i+1]) and writes the byte to shadow[LINE_LEN-1]. ptr stays at LINE_LEN. overflow is never set and is tied to 0.
- Undefined: drop-and-flag behaviour as described in Behaviour.

Decomposition:
- Package charbuf_pkg holds:
  - LINE_LEN_DEFAULT=11.
  - ASCII constants ASCII_NUL=8'd0, ASCII_BS=8'd8, ASCII_CR=8'd13.
  - Typedef char_t = logic [0:7].
  - State enum charbuf_state_e {ACCEPT, PENDING, SWAP}.
- One sub-module, sync_edge_detect: one register plus the edge compare, parameterised by polarity. It is reusable by the VGA controller's counters.

Test Plan:
1. Reset, then send "HOLA" (72,79,76,65), CR, then pulse vsync low. Required:
   - busy=1 after CR; char unchanged (all 0) before the edge.
   - On the cycle after the falling edge, char = {72,79,76,65,0,0,0,0,0,0,0}.
   - busy=0 and char_ready=1 one cycle later.
2. Send "ABC", BS, "D", CR, then an edge. Required: char[0:3]={65,66,68,0}. A BS with ptr==0 leaves the state unchanged.
3. Send 12 printable bytes "0".."9","A","B", CR, then an edge. Required:
   - Without CHARBUF_SCROLL_EN: char = "0".."9","A", and overflow=1 before SWAP, 0 after.
   - With CHARBUF_SCROLL_EN: char = "1".."9","A","B", and overflow=0.
4. CR, then hold char_valid=1 with 8'd88 for 50 cycles with no edge. Required: char_ready=0 throughout and nothing consumed. After the edge, 'X' is accepted as the first byte of the new shadow.
5. Send "XY", CR, assert reset for 1 cycle while PENDING, then an edge. Required: char stays all 0, busy=0, and the post-reset shadow is empty.
6. A vsync edge in ACCEPT with a partly typed "AB". Required: char unchanged; a later CR plus an edge shows "AB".
